// File: rtl/fifo_lane_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_lane_serializer_pkg
// Types and constants shared by the lane serializer and its statistics
// counters.
//   state_e     : serializer state (IDLE = no word held, EMIT = word held)
//   STAT_WIDTH  : width of the statistics counters
//   lane_idx_w  : width of a lane index for a given lane count
// -----------------------------------------------------------------------------
package fifo_lane_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam int STAT_WIDTH = 32;

    // A lane count of 1 would give a zero-width index; keep at least one bit.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/fifo_lane_serializer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a synchronous, active-high reset.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, clears the count
//   inc_i    : increment enable
//   count_o  : current count; holds at all-ones once reached
// -----------------------------------------------------------------------------
module sat_counter
    import fifo_lane_serializer_pkg::*;
#(
    parameter int WIDTH = STAT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fifo_lane_serializer.sv
// -----------------------------------------------------------------------------
// fifo_lane_serializer
// Drains wide words from a registered-output FIFO and presents them as a
// stream of narrow lanes (lane 0 = LSBs first) under valid/ready. The next
// word is dequeued in the same cycle the last lane transfers, so consecutive
// words stream without bubbles.
//
// Ports
//   CLK, RST      : clock, synchronous active-high reset
//   CLR           : synchronous flush, drops the held word
//   FIFO_D_OUT    : FIFO head word
//   FIFO_EMPTY_N  : FIFO has data
//   FIFO_DEQ      : combinational dequeue strobe to the FIFO
//   OUT_DATA      : current lane
//   OUT_VALID     : lane valid
//   OUT_READY     : consumer accepts lane
//   OUT_LAST      : current lane is the final lane of the word
//   OUT_LANE      : index of current lane
//   STAT_WORDS    : words dequeued (saturating)
//   STAT_STALLS   : cycles with OUT_VALID && !OUT_READY (saturating)
//
// Build option
//   SERIALIZER_STATS_EN : when defined, the statistics counters are built;
//                         otherwise STAT_WORDS / STAT_STALLS are tied to 0.
// -----------------------------------------------------------------------------
module fifo_lane_serializer
    import fifo_lane_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CLR,
    input  logic [WORD_WIDTH-1:0]        FIFO_D_OUT,
    input  logic                         FIFO_EMPTY_N,
    output logic                         FIFO_DEQ,
    output logic [LANE_WIDTH-1:0]        OUT_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic                         OUT_LAST,
    output logic [lane_idx_w(LANES)-1:0] OUT_LANE,
    output logic [STAT_WIDTH-1:0]        STAT_WORDS,
    output logic [STAT_WIDTH-1:0]        STAT_STALLS
);

    localparam int LIW = lane_idx_w(LANES);

    if (WORD_WIDTH != LANES * LANE_WIDTH) begin : g_bad_width
        $error("fifo_lane_serializer: WORD_WIDTH must equal LANES*LANE_WIDTH");
    end
    if (LANES < 2) begin : g_bad_lanes
        $error("fifo_lane_serializer: LANES must be at least 2");
    end

    state_e                state_q;
    state_e                state_d;
    logic [LIW-1:0]        lane_q;
    logic [LIW-1:0]        lane_d;
    logic [WORD_WIDTH-1:0] hold_q;
    logic [WORD_WIDTH-1:0] hold_d;

    logic transfer;
    logic last_lane;
    logic deq;

    assign OUT_VALID = (state_q == EMIT);
    assign last_lane = (state_q == EMIT) && (lane_q == LIW'(LANES - 1));
    assign transfer  = OUT_VALID && OUT_READY;

    // OUT_READY reaches the FIFO only through this term, which lets the next
    // word load in the same cycle the last lane leaves.
    assign deq = !RST && !CLR && FIFO_EMPTY_N &&
                 ((state_q == IDLE) || (transfer && last_lane));

    assign FIFO_DEQ = deq;
    assign OUT_LAST = last_lane;
    assign OUT_LANE = lane_q;

    // Lane mux over the held word.
    always_comb begin
        OUT_DATA = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LIW'(i)) begin
                OUT_DATA = hold_q[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Next-state: flush wins over load, load wins over lane advance.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        if (CLR) begin
            state_d = IDLE;
            lane_d  = '0;
        end else if (deq) begin
            state_d = EMIT;
            lane_d  = '0;
            hold_d  = FIFO_D_OUT;
        end else if (transfer) begin
            if (last_lane) begin
                state_d = IDLE;
            end else begin
                lane_d = lane_q + LIW'(1);
            end
        end
    end

    // Hold register is cleared by reset so OUT_DATA reads 0 out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            lane_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
        end
    end

`ifdef SERIALIZER_STATS_EN
    logic stall;
    assign stall = OUT_VALID && !OUT_READY;

    // Counters ignore CLR; only RST clears them.
    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_words_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (deq),
        .count_o (STAT_WORDS)
    );

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stalls_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (stall),
        .count_o (STAT_STALLS)
    );
`else
    assign STAT_WORDS  = '0;
    assign STAT_STALLS = '0;
`endif

endmodule

// File: tb/tb_fifo_lane_serializer.sv
module tb_fifo_lane_serializer;

    localparam int WW = 32;
    localparam int LN = 4;
    localparam int LW = 8;
    localparam int IW = $clog2(LN);

`ifdef SERIALIZER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [WW-1:0] dout = '0;
    logic          empty_n = 1'b0;
    logic          deq;
    logic [LW-1:0] odata;
    logic          vld;
    logic          rdy = 1'b1;
    logic          last;
    logic [IW-1:0] olane;
    logic [31:0]   sw;
    logic [31:0]   ss;

    fifo_lane_serializer #(
        .WORD_WIDTH (WW),
        .LANES      (LN),
        .LANE_WIDTH (LW)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .CLR          (clr),
        .FIFO_D_OUT   (dout),
        .FIFO_EMPTY_N (empty_n),
        .FIFO_DEQ     (deq),
        .OUT_DATA     (odata),
        .OUT_VALID    (vld),
        .OUT_READY    (rdy),
        .OUT_LAST     (last),
        .OUT_LANE     (olane),
        .STAT_WORDS   (sw),
        .STAT_STALLS  (ss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] data;
        int            lane;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    logic [WW-1:0] fifo_q[$];
    int            errors = 0;
    int            checks = 0;
    bit            deq_s;
    bit            vld_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic void refresh();
        empty_n = (fifo_q.size() != 0);
        dout    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    // Reference model: every word entering the FIFO leaves as LANES lanes,
    // LSB lane first, last flag on the final lane.
    task automatic enq(input logic [WW-1:0] w);
        exp_t e;
        fifo_q.push_back(w);
        for (int i = 0; i < LN; i++) begin
            e.data = w[i*LW +: LW];
            e.lane = i;
            e.last = (i == LN - 1);
            exp_q.push_back(e);
        end
        refresh();
    endtask

    task automatic tick();
        @(negedge clk);
        deq_s = deq;
        vld_s = vld;
        @(posedge clk);
        #1;
        if (deq_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic drain();
        rdy = 1'b1;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || fifo_q.size() != 0); i++) tick();
        chk("drain_expected_left", exp_q.size(), 0);
        chk("drain_fifo_left", fifo_q.size(), 0);
    endtask

    // Monitor: compares every transferred lane against the scoreboard and
    // checks that a stalled lane stays put.
    logic          p_vld = 1'b0;
    logic          p_rdy = 1'b0;
    logic          p_clr = 1'b0;
    logic          p_rst = 1'b1;
    logic [LW-1:0] p_data = '0;
    logic [IW-1:0] p_lane = '0;
    exp_t          m_e;

    always @(negedge clk) begin
        if (p_vld && !p_rdy && !p_clr && !p_rst) begin
            chk("stall_valid", vld, 1);
            chk("stall_data", odata, p_data);
            chk("stall_lane", olane, p_lane);
        end
        if (vld && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_lane: got data %0h lane %0d, nothing expected", odata, olane);
            end else begin
                m_e = exp_q.pop_front();
                chk("lane_data", odata, m_e.data);
                chk("lane_index", olane, m_e.lane);
                chk("lane_last", last, m_e.last);
            end
        end
        if (deq) chk("deq_needs_data", empty_n, 1);
        p_vld  = vld;
        p_rdy  = rdy;
        p_clr  = clr;
        p_rst  = rst;
        p_data = odata;
        p_lane = olane;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [9:0] dh;
    logic [9:0] vh;
    int         rnd_sent;

    initial begin
        // Reset with a word already waiting: nothing may be dequeued.
        tick();
        tick();
        enq(32'hDDCCBBAA);
        tick();
        chk("deq_during_reset", deq_s, 0);
        chk("rst_valid", vld, 0);
        chk("rst_last", last, 0);
        chk("rst_lane", olane, 0);
        chk("rst_data", odata, 0);
        chk("rst_stat_words", sw, 0);
        chk("rst_stat_stalls", ss, 0);

        // Single word: dequeue in cycle 0, lanes on cycles 1..4.
        rst = 1'b0;
        dh = '0;
        vh = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            dh[c] = deq_s;
            vh[c] = vld_s;
        end
        chk("t1_deq_pattern", {24'd0, dh[7:0]}, 32'h01);
        chk("t1_valid_pattern", {24'd0, vh[7:0]}, 32'h1E);

        // Two words back to back: no bubble, dequeues on cycles 0 and 4.
        enq(32'h04030201);
        enq(32'h08070605);
        for (int c = 0; c < 10; c++) begin
            tick();
            dh[c] = deq_s;
            vh[c] = vld_s;
        end
        chk("t2_deq_pattern", {22'd0, dh}, 32'h011);
        chk("t2_valid_pattern", {22'd0, vh}, 32'h1FE);
        chk("t2_stat_words", sw, STATS ? 32'd3 : 32'd0);
        chk("t2_stat_stalls", ss, 0);

        // Stall three cycles on lane 2.
        enq(32'h44332211);
        tick();
        tick();
        tick();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("t3_hold_data", odata, 32'h33);
            chk("t3_hold_lane", olane, 2);
            chk("t3_hold_valid", vld, 1);
            tick();
        end
        rdy = 1'b1;
        chk("t3_stat_stalls", ss, STATS ? 32'd3 : 32'd0);
        drain();

        // Flush during lane 1 with the FIFO non-empty.
        enq(32'h1D1C1B1A);
        enq(32'h2D2C2B2A);
        tick();
        tick();
        clr = 1'b1;
        tick();
        chk("t4_deq_in_clr", deq_s, 0);
        clr = 1'b0;
        chk("t4_valid_after_clr", vld, 0);
        repeat (LN - 2) void'(exp_q.pop_front());
        tick();
        chk("t4_deq_after_clr", deq_s, 1);
        chk("t4_restart_lane", olane, 0);
        chk("t4_restart_data", odata, 32'h2A);
        chk("t4_restart_valid", vld, 1);
        drain();
        chk("t4_stat_words", sw, STATS ? 32'd6 : 32'd0);
        chk("t4_stat_stalls", ss, STATS ? 32'd3 : 32'd0);

        // Reset during lane 3 with another word waiting.
        enq(32'h3D3C3B3A);
        tick();
        tick();
        tick();
        tick();
        chk("t5_on_lane3", olane, 3);
        enq(32'h4D4C4B4A);
        rst = 1'b1;
        tick();
        chk("t5_deq_in_rst", deq_s, 0);
        rst = 1'b0;
        chk("t5_rst_valid", vld, 0);
        chk("t5_rst_last", last, 0);
        chk("t5_rst_lane", olane, 0);
        chk("t5_rst_data", odata, 0);
        chk("t5_rst_stat_words", sw, 0);
        chk("t5_rst_stat_stalls", ss, 0);
        drain();

        // Randomised traffic and backpressure.
        rnd_sent = 0;
        for (int c = 0; c < 3000 && rnd_sent < 40; c++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 2) != 0) begin
                enq($urandom);
                rnd_sent++;
            end
            rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        chk("rand_words_sent", rnd_sent, 40);
        drain();
        chk("final_stat_words", sw, STATS ? 32'd41 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
